pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 32-bit ripple adder in the ALU.
- Splits the WIDTH-bit carry chain into STAGES registered slices. Each slice's carry is registered into the next slice, so throughput is one operation per clock with STAGES cycles of latency.
- Adds a per-operation add/sub mode, valid/ready handshakes with backpressure, and full status flags (carry, signed overflow, zero, negative).
- Sits between the ALU operand mux and the result writeback.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- STAGES, 4, pipeline depth; must be >= 1 and divide WIDTH.
- SLICE = WIDTH/STAGES, derived (not overridable): bits resolved per stage.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: Y=A+B; 1: Y=A-B
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- y  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB (for sub: 1 = no borrow, i.e. A>=B unsigned)
- ovf  out  1  signed overflow for the selected operation
- zero  out  1  y == 0
- neg  out  1  y[WIDTH-1]

Behaviour:
- Effective operand: Beff = sub ? ~b : b; carry-in to slice 0 = sub.
- Stage k (0..STAGES-1):
  - adds bits [k*SLICE +: SLICE] of A and Beff with the registered carry from stage k-1.
  - registers its sum slice, its carry out, and the not-yet-consumed upper operand bits (A and Beff, skew registers).
  - carries forward the already-computed lower sum bits and a valid bit.
- Flags are computed from final-stage values and registered with y:
  - ovf = (A[MSB] == Beff[MSB]) && (y[MSB] != A[MSB]), equivalently carry-into-MSB XOR cout.
  - zero and neg are derived from the full y.
- Latency: a beat accepted at edge N (in_valid && in_ready) presents out_valid=1 with its result after edge N+STAGES, provided there is no stall.
- Handshake:
  - Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv=1, every stage loads from its predecessor; stage 0 loads in_valid. Bubbles (valid=0) propagate and do not block.
  - When adv=0, all stage registers hold; y and flags are stable while out_valid=1 && out_ready=0.
  - a, b and sub are sampled only on acceptance; inputs are don't-care otherwise.
- Simultaneous accept and retire in the same cycle is legal and sustains 1 beat/clock.
- Results leave in acceptance order; no beat is dropped or duplicated.
- Reset:
  - Asynchronous assert: all valid bits, y, cout, ovf, zero, neg go to 0 immediately. in_ready reads 1 (out_valid=0).
  - Reset mid-operation discards all in-flight beats.
  - Deassertion is followed by normal operation on the next edge.
- STAGES=1: single registered ripple add, latency 1.
- STAGES=WIDTH: one bit per stage.
- Arithmetic wraps modulo 2^WIDTH; cout and ovf are the only indication of wrap.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1: a=0x0000_0005, b=0x0000_0003, sub=0 accepted at edge 0 -> at edge 4 out_valid=1, y=0x0000_0008, cout=0, ovf=0, zero=0, neg=0.
- Add overflow and cross-slice carry: a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> y=0x8000_0000, ovf=1, neg=1, cout=0. Then a=0xFFFF_FFFF, b=0x0000_0001 -> y=0, cout=1, zero=1, ovf=0.
- Subtract: a=0x8000_0000, b=0x0000_0001, sub=1 -> y=0x7FFF_FFFF, ovf=1, cout=1. a=3, b=5, sub=1 -> y=0xFFFF_FFFE, cout=0, neg=1, ovf=0.
- Back-to-back and backpressure:
  - Stream 8 random beats on consecutive cycles and hold out_ready=0 for 3 cycles mid-stream.
  - Require: in_ready=0 during the hold, y stable while stalled, all 8 results in order and matching a reference model.
- Bubbles: assert in_valid on alternate cycles -> out_valid pattern is the same alternation delayed 4 cycles.
- Reset mid-flight: 3 beats in flight, assert reset asynchronously between edges -> out_valid=0 and y=0 immediately. After release, none of the 3 beats appear. Repeat the directed cases with STAGES=1 and STAGES=32 for parameter coverage.

Source files
------------

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipe_addsub
// Description : Pipelined two's-complement adder/subtractor. The WIDTH-bit
//               carry chain is cut into STAGES registered slices. Each stage
//               resolves SLICE bits and forwards its carry, the finished lower
//               sum bits and the unconsumed upper operand bits. Carry, signed
//               overflow, zero and negative flags are registered with y.
//               Valid/ready handshake with a single global advance signal.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub #(
  parameter int WIDTH  = 32,  // >= 2
  parameter int STAGES = 4    // >= 1, must divide WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SLICE = WIDTH / STAGES;

  // Whole pipeline moves together; it only stalls when a result is waiting
  // and downstream refuses it.
  logic             w_adv;
  logic [WIDTH-1:0] w_beff;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Subtraction is A + ~B + 1; the +1 enters as carry-in of slice 0.
  assign w_beff = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;   // first bit resolved by this stage
    localparam int HI = LO + SLICE;  // one past the last bit resolved here

    // Stage inputs: operand bits [WIDTH-1:LO], carry-in, lower sum bits
    logic                vld_in;
    logic                cin;
    logic [WIDTH-LO-1:0] a_up;
    logic [WIDTH-LO-1:0] b_up;

    // Slice arithmetic and next-state values
    logic [SLICE:0]      slice_sum;
    logic [HI-1:0]       sum_d;
    logic                carry_d;

    // Stage registers
    logic                vld_q;
    logic                carry_q;
    logic [HI-1:0]       sum_q;

    if (k == 0) begin : g_head
      assign vld_in = in_valid;
      assign cin    = sub;
      assign a_up   = a;
      assign b_up   = w_beff;
      assign sum_d  = slice_sum[SLICE-1:0];
    end else begin : g_body
      assign vld_in = g_stage[k-1].vld_q;
      assign cin    = g_stage[k-1].carry_q;
      assign a_up   = g_stage[k-1].g_skew.opa_q;
      assign b_up   = g_stage[k-1].g_skew.opb_q;
      assign sum_d  = {slice_sum[SLICE-1:0], g_stage[k-1].sum_q};
    end

    assign slice_sum = {1'b0, a_up[SLICE-1:0]}
                     + {1'b0, b_up[SLICE-1:0]}
                     + {{SLICE{1'b0}}, cin};
    assign carry_d   = slice_sum[SLICE];

    // Valid, carry and accumulated sum bits advance one stage per clock
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (w_adv) begin
        vld_q   <= vld_in;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      // Operand bits above this slice, still waiting for their stage
      logic [WIDTH-HI-1:0] opa_q;
      logic [WIDTH-HI-1:0] opb_q;

      // Skew registers delay the upper operand bits to meet their carry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (w_adv) begin
          opa_q <= a_up[WIDTH-LO-1:SLICE];
          opb_q <= b_up[WIDTH-LO-1:SLICE];
        end
      end
    end else begin : g_tail
      // The final slice holds the MSB, so sign-based flags resolve here
      logic ovf_d;
      logic zero_d;
      logic ovf_q;
      logic zero_q;

      assign ovf_d  = (a_up[SLICE-1] == b_up[SLICE-1]) &&
                      (slice_sum[SLICE-1] != a_up[SLICE-1]);
      assign zero_d = (sum_d == '0);

      // Flags are captured in the same register stage as y
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (w_adv) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign y         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;
  assign zero      = g_stage[STAGES-1].g_tail.zero_q;
  assign neg       = y[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_addsub
// Description : Self-checking bench for pipe_addsub. Three instances
//               (STAGES = 1, 4, 32) share operand inputs for the directed
//               table; the 4-stage instance also gets streaming,
//               backpressure, bubble and mid-flight reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] y;
    logic         c;
    logic         o;
    logic         z;
    logic         n;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic         one = 1'b1;

  logic         rdy1, ov1, c1, o1, z1, n1;
  logic         rdy4, ov4, c4, o4, z4, n4;
  logic         rdy32, ov32, c32, o32, z32, n32;
  logic [W-1:0] y1, y4, y32;

  int checks = 0;
  int errors = 0;

  vec_t         vecs[10];
  vec_t         q[$];
  int           n_acc;
  int           n_ret;
  logic         pend = 1'b0;
  logic [W-1:0] pa, pb;
  logic         psub;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .sub(sub), .out_valid(ov1), .out_ready(one),
    .y(y1), .cout(c1), .ovf(o1), .zero(z1), .neg(n1));

  pipe_addsub #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4),
    .a(a), .b(b), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
    .y(y4), .cout(c4), .ovf(o4), .zero(z4), .neg(n4));

  pipe_addsub #(.WIDTH(W), .STAGES(32)) u_s32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .a(a), .b(b), .sub(sub), .out_valid(ov32), .out_ready(one),
    .y(y32), .cout(c32), .ovf(o32), .zero(z32), .neg(n32));

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic vld, input logic [W-1:0] yy,
                         input logic cc, input logic oo, input logic zz, input logic nn,
                         input vec_t e);
    chk({tag, "_valid"}, W'(vld), W'(1));
    chk({tag, "_y"},     yy,      e.y);
    chk({tag, "_cout"},  W'(cc),  W'(e.c));
    chk({tag, "_ovf"},   W'(oo),  W'(e.o));
    chk({tag, "_zero"},  W'(zz),  W'(e.z));
    chk({tag, "_neg"},   W'(nn),  W'(e.n));
  endtask

  // Reference: unsigned compare for borrow, sign rules for overflow
  function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    vec_t v;
    logic [W:0] s;
    v.a = ma; v.b = mb; v.sub = ms;
    if (ms) begin
      v.y = ma - mb;
      v.c = (ma >= mb);
      v.o = (ma[W-1] != mb[W-1]) && (v.y[W-1] != ma[W-1]);
    end else begin
      s   = {1'b0, ma} + {1'b0, mb};
      v.y = s[W-1:0];
      v.c = s[W];
      v.o = (ma[W-1] == mb[W-1]) && (v.y[W-1] != ma[W-1]);
    end
    v.z = (v.y == '0);
    v.n = v.y[W-1];
    return v;
  endfunction

  // One clock on the 4-stage instance with scoreboard bookkeeping.
  // Called at the post-edge sampling point; returns there one clock later.
  task automatic cycle(input logic iv, input logic orr, output logic rdy_s);
    vec_t e;
    if (iv && !pend) begin
      pa   = $urandom;
      pb   = $urandom;
      psub = 1'($urandom_range(0, 1));
      pend = 1'b1;
    end
    in_valid  = iv;
    a         = pa;
    b         = pb;
    sub       = psub;
    out_ready = orr;
    #1;
    rdy_s = rdy4;
    if (ov4 && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got y=%h expected no beat", y4);
      end else begin
        e = q.pop_front();
        chk_res("retire", ov4, y4, c4, o4, z4, n4, e);
      end
      n_ret++;
    end
    if (in_valid && rdy4) begin
      q.push_back(model(pa, pb, psub));
      pend = 1'b0;
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic         rdy;
    logic         stall;
    logic         exp_ov;
    logic [W-1:0] yhold;

    //         a             b             sub   y             c     o     z     n
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, all three depths
    #1;
    chk("rst_ov4", W'(ov4), W'(0));   chk("rst_y4", y4, '0);
    chk("rst_rdy4", W'(rdy4), W'(1)); chk("rst_flags4", W'({c4, o4, z4, n4}), W'(0));
    chk("rst_ov1", W'(ov1), W'(0));   chk("rst_rdy1", W'(rdy1), W'(1));
    chk("rst_ov32", W'(ov32), W'(0)); chk("rst_rdy32", W'(rdy32), W'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: one beat, then each depth must answer at exactly its latency
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a        = vecs[i].a;
      b        = vecs[i].b;
      sub      = vecs[i].sub;
      chk("dir_rdy4", W'(rdy4), W'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 32; c++) begin
        if (c == 1)  chk_res($sformatf("v%0d_s1", i), ov1, y1, c1, o1, z1, n1, vecs[i]);
        else         chk("s1_idle", W'(ov1), W'(0));
        if (c == 4)  chk_res($sformatf("v%0d_s4", i), ov4, y4, c4, o4, z4, n4, vecs[i]);
        else         chk("s4_idle", W'(ov4), W'(0));
        if (c == 32) chk_res($sformatf("v%0d_s32", i), ov32, y32, c32, o32, z32, n32, vecs[i]);
        else         chk("s32_idle", W'(ov32), W'(0));
        @(posedge clk);
        #1;
      end
    end

    // Stream 8 beats back to back with a 3-cycle stall mid-stream
    n_acc = 0;
    n_ret = 0;
    for (int t = 0; t < 60 && n_ret < 8; t++) begin
      stall = (t >= 5 && t <= 7);
      if (stall) begin
        chk("stall_ov", W'(ov4), W'(1));
        if (t == 5) yhold = y4;
        else        chk("stall_y", y4, yhold);
      end
      if (t == 8) chk("post_stall_y", y4, yhold);
      cycle(n_acc < 8, !stall, rdy);
      if (stall) chk("stall_rdy", W'(rdy), W'(0));
    end
    chk("stream_count", W'(n_ret), W'(8));
    chk("stream_drain", W'(q.size()), W'(0));

    // Bubbles: alternate valid, output pattern is the same delayed 4 clocks
    n_ret = 0;
    for (int t = 0; t < 16; t++) begin
      exp_ov = (t >= 4) && (t <= 11) && (t % 2 == 0);
      chk($sformatf("bubble_ov_t%0d", t), W'(ov4), W'(exp_ov));
      cycle((t < 8) && (t % 2 == 0), 1'b1, rdy);
    end
    chk("bubble_count", W'(n_ret), W'(4));

    // Mid-flight reset: one beat at the output and three behind it are discarded
    n_ret = 0;
    repeat (4) cycle(1'b1, 1'b1, rdy);
    in_valid = 1'b0;
    chk("pre_rst_ov", W'(ov4), W'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ov", W'(ov4), W'(0));
    chk("async_rst_y", y4, '0);
    chk("async_rst_flags", W'({c4, o4, z4, n4}), W'(0));
    chk("async_rst_rdy", W'(rdy4), W'(1));
    q.delete();
    pend = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (12) cycle(1'b0, 1'b1, rdy);
    chk("rst_discard", W'(n_ret), W'(0));

    // Normal operation resumes after reset
    cycle(1'b1, 1'b1, rdy);
    repeat (6) cycle(1'b0, 1'b1, rdy);
    chk("post_rst_count", W'(n_ret), W'(1));
    chk("post_rst_drain", W'(q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
